// File: rtl/serial_adder_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl_pkg
//   Shared definitions for the bit-serial adder controller:
//     - FSM state encoding (IDLE=0, RUN=1, DONE=2)
//     - legal WIDTH range and a helper to test it at elaboration time
//   Imported by serial_adder_ctrl.
// -----------------------------------------------------------------------------
package serial_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  function automatic bit width_ok(input int width);
    return (width >= WIDTH_MIN) && (width <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//   One-bit combinational full adder; the single arithmetic cell shared by
//   every bit position of the serial adder.
// Ports:
//   A, B   in  1  addend bits
//   Cin    in  1  carry in
//   Cout   out 1  carry out
//   S      out 1  sum bit
// -----------------------------------------------------------------------------
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Cout,
  output logic S
);

  logic p;

  assign p    = A ^ B;
  assign S    = p ^ Cin;
  assign Cout = (A & B) | (Cin & p);

endmodule

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//   Bit-serial WIDTH-bit adder. A start pulse in IDLE latches A, B and Cin;
//   the operands are then fed LSB-first through one full_adder, one bit per
//   clock, with the carry held in a flop between bits. After WIDTH cycles in
//   RUN the sum and carry-out are registered and done pulses for one cycle.
//
// Parameters:
//   WIDTH  operand/sum width, 2..32 (default 8)
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous active-high reset
//   start  in   1      request, sampled in IDLE only
//   A, B   in   WIDTH  operands, sampled on the accepting edge
//   Cin    in   1      carry-in, sampled on the accepting edge
//   SUB    in   1      (only with SERIAL_ADDER_SUB_EN) 1 = compute A - B
//   busy   out  1      high while in RUN
//   done   out  1      one-cycle pulse; S/Cout valid from this cycle on
//   S      out  WIDTH  registered sum, held until the next accepted start
//   Cout   out  1      registered carry-out (no-borrow flag when subtracting)
//
// Configuration:
//   SERIAL_ADDER_SUB_EN  when defined, adds the SUB port and subtract mode.
// -----------------------------------------------------------------------------
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             SUB,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("serial_adder_ctrl: WIDTH must be in 2..32");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q,  a_sh_d;
  logic [WIDTH-1:0]   b_sh_q,  b_sh_d;
  logic [WIDTH-1:0]   s_sh_q,  s_sh_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [WIDTH-1:0]   s_q,     s_d;
  logic               cout_q,  cout_d;

  // ---------------------------------------------------------------------------
  // Operand conditioning at load time. Subtraction is A + ~B + 1, so the
  // caller's Cin is replaced by the forced 1.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] b_load;
  logic             c_load;

`ifdef SERIAL_ADDER_SUB_EN
  assign b_load = SUB ? ~B   : B;
  assign c_load = SUB ? 1'b1 : Cin;
`else
  assign b_load = B;
  assign c_load = Cin;
`endif

  // ---------------------------------------------------------------------------
  // Shared one-bit adder
  // ---------------------------------------------------------------------------
  logic fa_s, fa_cout;

  full_adder u_fa (
    .A    (a_sh_q[0]),
    .B    (b_sh_q[0]),
    .Cin  (carry_q),
    .Cout (fa_cout),
    .S    (fa_s)
  );

  // Sum shifter with the new bit entering at the MSB; after WIDTH shifts the
  // first (LSB) bit has reached position 0.
  logic [WIDTH-1:0] s_next;
  assign s_next = WIDTH'({fa_s, s_sh_q} >> 1);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  // NOTE: every register, datapath included, is reset so an abort mid-RUN
  // leaves no stale partial result visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / datapath
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here is given a hold default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    cout_d  = cout_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          a_sh_d  = A;
          b_sh_d  = b_load;
          carry_d = c_load;
          cnt_d   = '0;
        end
      end

      ST_RUN: begin
        s_sh_d  = s_next;
        carry_d = fa_cout;
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        if (cnt_q == CNT_LAST) begin
          // Last bit: publish the result; cnt stays put so it never wraps.
          state_d = ST_DONE;
          s_d     = s_next;
          cout_d  = fa_cout;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from the state register, so busy and done are mutually
  // exclusive by construction.
  // ---------------------------------------------------------------------------
  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign S    = s_q;
  assign Cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_ctrl
//   Self-checking bench for serial_adder_ctrl (WIDTH=8). Expected results are
//   computed from the operands when a request is issued, queued, and compared
//   when done is seen. Subtract cases run only with SERIAL_ADDER_SUB_EN.
// -----------------------------------------------------------------------------
module tb_serial_adder_ctrl;

  localparam int W       = 8;
  localparam int TIMEOUT = 40;

  typedef struct {
    logic [W-1:0] s;
    logic         cout;
    string        tag;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic         SUB;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] S;
  logic         Cout;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
`ifdef SERIAL_ADDER_SUB_EN
    .SUB   (SUB),
`endif
    .busy  (busy),
    .done  (done),
    .S     (S),
    .Cout  (Cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a request for one cycle and queue the reference result. Returns at
  // the falling edge after the accepting edge (first RUN cycle).
  task automatic issue(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub);
    exp_t         e;
    logic [W:0]   sum;
    if (sub) sum = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    else     sum = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
    e.s    = sum[W-1:0];
    e.cout = sum[W];
    e.tag  = tag;
    @(negedge clk);
    A     = a;
    B     = b;
    Cin   = cin;
`ifdef SERIAL_ADDER_SUB_EN
    SUB   = sub;
`endif
    start = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for done, counting busy cycles (pre_busy already observed by the
  // caller), then compare against the head of the queue.
  task automatic wait_result(input int pre_busy);
    int   nbusy   = pre_busy;
    bit   seen    = 0;
    bit   overlap = 0;
    exp_t e;
    for (int i = 0; i < TIMEOUT; i++) begin
      if (busy && done) overlap = 1;
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) nbusy++;
      @(negedge clk);
    end
    e = exp_q.pop_front();
    check({e.tag, " done_seen"}, 32'(seen), 32'd1);
    check({e.tag, " busy_cycles"}, nbusy, W);
    check({e.tag, " busy_done_overlap"}, 32'(overlap), 32'd0);
    check({e.tag, " S"}, 32'(S), 32'(e.s));
    check({e.tag, " Cout"}, 32'(Cout), 32'(e.cout));
    @(negedge clk);
    check({e.tag, " done_single"}, 32'(done), 32'd0);
    check({e.tag, " S_held"}, 32'(S), 32'(e.s));
  endtask

  initial begin
    int extra_done;
    int extra_busy;
    exp_t dropped;

    // Reset with start held high: nothing may start.
    rst   = 1'b1;
    start = 1'b1;
    A     = 8'hA5;
    B     = 8'h5A;
    Cin   = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    SUB   = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset S",    32'(S),    32'h00);
    check("reset Cout", 32'(Cout), 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("idle busy", 32'(busy), 32'd0);

    // Basic add.
    issue("add_2b_14", 8'h2B, 8'h14, 1'b0, 1'b0);
    wait_result(0);

    // Carry chains.
    issue("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
    wait_result(0);
    issue("add_ff_ff_c1", 8'hFF, 8'hFF, 1'b1, 1'b0);
    wait_result(0);

    // start during RUN is ignored; exactly one done pulse.
    issue("ignore_busy", 8'h10, 8'h01, 1'b0, 1'b0);  // RUN cycle 1
    @(negedge clk);                                   // RUN cycle 2
    @(negedge clk);                                   // RUN cycle 3
    A     = 8'hAA;
    B     = 8'h55;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_result(3);
    extra_done = 0;
    extra_busy = 0;
    for (int i = 0; i < W + 4; i++) begin
      if (done) extra_done++;
      if (busy) extra_busy++;
      @(negedge clk);
    end
    check("ignore_busy extra_done", extra_done, 0);
    check("ignore_busy no_queue",   extra_busy, 0);

    // Abort mid-RUN at cnt=3.
    issue("abort", 8'h33, 8'h44, 1'b0, 1'b0);        // cnt=0
    repeat (3) @(negedge clk);                        // cnt=3
    dropped = exp_q.pop_front();
    rst = 1'b1;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort S",    32'(S),    32'h00);
    check("abort Cout", 32'(Cout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort idle", 32'(busy), 32'd0);
    issue("after_abort", 8'h01, 8'h01, 1'b0, 1'b0);
    wait_result(0);

    // A few random additions.
    for (int i = 0; i < 4; i++) begin
      issue("rand_add", W'($urandom), W'($urandom), 1'($urandom), 1'b0);
      wait_result(0);
    end

`ifdef SERIAL_ADDER_SUB_EN
    issue("sub_05_07", 8'h05, 8'h07, 1'b1, 1'b1);
    wait_result(0);
    issue("sub_07_05", 8'h07, 8'h05, 1'b0, 1'b1);
    wait_result(0);
    issue("sub0_add", 8'h2B, 8'h14, 1'b1, 1'b0);
    wait_result(0);
`endif

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
